// File: rtl/rf_instr_sequencer.sv
// Instruction sequencer feeding the 8-bit register file: decodes 12-bit words, sequences reads/writes.
// Optional illegal-instruction detection (dst = 00) is enabled by defining RF_SEQ_ERR_EN.
module rf_instr_sequencer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [11:0]       instr,
    output logic              instr_ready,
    output logic [4:0]        rf_read_reg_1,
    input  logic [DATA_W-1:0] rf_read_data_1,
    output logic [1:0]        rf_write_reg,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_ADDR, S_RD_WAIT, S_WRITE, S_RETIRE, S_ERROR
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_LDI  = 2'b01,
        OP_MOV  = 2'b10,
        OP_ADDI = 2'b11
    } opcode_t;

    state_t             state, next;
    opcode_t            op_q;
    logic [1:0]         dst_q;
    logic [DATA_W-1:0]  imm_q;

    opcode_t            in_op;
    logic [1:0]         in_dst;
    logic               accept;
    logic               illegal;

    logic [4:0]         rd_reg_d;
    logic [1:0]         wr_reg_d;
    logic [DATA_W-1:0]  wr_data_d;
    logic               done_d;
    logic               err_d;

    assign in_op       = opcode_t'(instr[11:10]);
    assign in_dst      = instr[9:8];
    assign accept      = instr_valid && (state == S_IDLE);
    assign instr_ready = (state == S_IDLE) && !rst;
    assign busy        = (state != S_IDLE);

`ifdef RF_SEQ_ERR_EN
    assign illegal = (in_op != OP_NOP) && (in_dst == 2'b00);
`else
    assign illegal = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (illegal)                next = S_ERROR;
                    else if (in_op == OP_NOP)   next = S_RETIRE;
                    else if (in_op == OP_LDI)   next = S_WRITE;
                    else                        next = S_RD_ADDR;
                end
            end
            S_RD_ADDR: next = S_RD_WAIT;
            S_RD_WAIT: next = S_WRITE;
            default:   next = S_IDLE;
        endcase
    end

    // Outputs are registered, so their next values are decoded from the upcoming state.
    always_comb begin
        rd_reg_d  = rf_read_reg_1;
        wr_reg_d  = '0;
        wr_data_d = rf_write_data;
        done_d    = (next == S_WRITE) || (next == S_RETIRE);
        err_d     = (next == S_ERROR);
        if (state == S_IDLE) begin
            if (next == S_RD_ADDR) begin
                rd_reg_d = {3'b000, (in_op == OP_MOV) ? instr[1:0] : in_dst};
            end
            if (next == S_WRITE) begin
                wr_reg_d  = in_dst;
                wr_data_d = instr[DATA_W-1:0];
            end
        end else if (state == S_RD_WAIT) begin
            wr_reg_d  = dst_q;
            wr_data_d = rf_read_data_1 + ((op_q == OP_ADDI) ? imm_q : '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q          <= OP_NOP;
            dst_q         <= '0;
            imm_q         <= '0;
            rf_read_reg_1 <= '0;
            rf_write_reg  <= '0;
            rf_write_data <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            if (accept) begin
                op_q  <= in_op;
                dst_q <= in_dst;
                imm_q <= instr[DATA_W-1:0];
            end
            rf_read_reg_1 <= rd_reg_d;
            rf_write_reg  <= wr_reg_d;
            rf_write_data <= wr_data_d;
            done          <= done_d;
            err           <= err_d;
        end
    end

endmodule
